// File: rtl/ring_arb_pkg.sv
// Shared types and width helpers for the ring token arbiter.
package ring_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/ring_token_reg.sv
// One-hot token register: resets to requester 0, loads one-hot(idx+1 mod NUM_REQ).
module ring_token_reg
  import ring_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               load,
  input  logic [IW-1:0]      idx,
  output logic [NUM_REQ-1:0] token
);

  if (NUM_REQ == 1) begin : g_single
    assign token = 1'b1;
  end else begin : g_ring
    logic [NUM_REQ-1:0] token_nxt;

    always_comb begin
      token_nxt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IW'(i) == idx) token_nxt[(i + 1) % NUM_REQ] = 1'b1;
      end
    end

    always_ff @(posedge CK) begin
      if (!RST) token <= NUM_REQ'(1);
      else if (load) token <= token_nxt;
    end
  end

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin token arbiter with held grants; define RING_ARB_TIMEOUT_EN to
// force release after MAX_HOLD consecutive grant cycles.
//
// state | meaning
// IDLE  | no grant; search from token for a winner when EN=1
// GRANT | GNT held until the winner drops REQ (or hold limit)
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 255
) (
  input  logic                           CK,
  input  logic                           RST,
  input  logic                           EN,
  input  logic [NUM_REQ-1:0]             REQ,
  output logic [NUM_REQ-1:0]             GNT,
  output logic [idx_width(NUM_REQ)-1:0]  GNT_IDX,
  output logic                           BUSY,
  output logic                           TIMEOUT
);

  localparam int IW = idx_width(NUM_REQ);

  if (NUM_REQ < 1 || NUM_REQ > 32 || MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_param
    $error("ring_token_arbiter: NUM_REQ or MAX_HOLD out of range");
  end

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] token;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IW-1:0]      idx_nxt;
  logic [IW-1:0]      tok_pos;
  logic [IW-1:0]      winner;
  logic               found;
  logic               tok_load;
  logic               limit_hit;

  ring_token_reg #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_token (
    .CK    (CK),
    .RST   (RST),
    .load  (tok_load),
    .idx   (GNT_IDX),
    .token (token)
  );

  always_comb begin
    tok_pos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (token[i]) tok_pos = IW'(i);
    end
  end

  // Walk offsets from the far end down so the smallest offset from the token wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (REQ[(int'(tok_pos) + i) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IW'((int'(tok_pos) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT;
    idx_nxt   = GNT_IDX;
    tok_load  = 1'b0;
    case (state)
      IDLE: begin
        if (EN && found) begin
          state_nxt       = GRANT;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          idx_nxt         = winner;
        end
      end
      GRANT: begin
        if (!REQ[GNT_IDX] || limit_hit) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          idx_nxt   = '0;
          tok_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RST) begin
      state   <= IDLE;
      GNT     <= '0;
      GNT_IDX <= '0;
    end else begin
      state   <= state_nxt;
      GNT     <= gnt_nxt;
      GNT_IDX <= idx_nxt;
    end
  end

  assign BUSY = (state == GRANT);

`ifdef RING_ARB_TIMEOUT_EN
  localparam int CW = cnt_width(MAX_HOLD);

  logic [CW-1:0] hold_cnt;
  logic          timeout_q;

  // hold_cnt equals (grant cycles so far - 1); the limit fires in the MAX_HOLD-th cycle.
  assign limit_hit = (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge CK) begin
    if (!RST) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_cnt  <= (state == GRANT) ? hold_cnt + CW'(1) : '0;
      timeout_q <= (state == GRANT) && REQ[GNT_IDX] && limit_hit;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign limit_hit = 1'b0;
  assign TIMEOUT   = 1'b0;
`endif

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Scoreboard bench for ring_token_arbiter (NUM_REQ=4, MAX_HOLD=8).
module tb_ring_token_arbiter;

  logic       CK;
  logic       RST;
  logic       EN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] GNT_IDX;
  logic       BUSY;
  logic       TIMEOUT;

  ring_token_arbiter #(
    .NUM_REQ  (4),
    .MAX_HOLD (8)
  ) dut (
    .CK      (CK),
    .RST     (RST),
    .EN      (EN),
    .REQ     (REQ),
    .GNT     (GNT),
    .GNT_IDX (GNT_IDX),
    .BUSY    (BUSY),
    .TIMEOUT (TIMEOUT)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } vec_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] req,
                              input logic [3:0] gnt, input logic [1:0] idx,
                              input logic busy, input logic to);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req;
    v.gnt = gnt; v.idx = idx; v.busy = busy; v.to = to;
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.gnt = v.gnt; e.idx = v.idx; e.busy = v.busy; e.to = v.to;
    return e;
  endfunction

  task automatic test_reset();
    vec_t v[$];
    exp_t x;
    v.push_back(mk(0, 1, 4'b1111, 4'b0000, 0, 0, 0));
    v.push_back(mk(0, 1, 4'b1111, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b1111, 4'b0001, 0, 1, 0));
    v.push_back(mk(1, 1, 4'b1110, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    foreach (v[i]) begin
      RST = v[i].rst; EN = v[i].en; REQ = v[i].req;
      exp_q.push_back(to_exp(v[i]));
      @(posedge CK); #1;
      x = exp_q.pop_front();
      n_total++;
      if (GNT !== x.gnt || GNT_IDX !== x.idx || BUSY !== x.busy || TIMEOUT !== x.to)
        $display("FAIL reset[%0d] got gnt=%b idx=%0d busy=%b to=%b want gnt=%b idx=%0d busy=%b to=%b",
                 i, GNT, GNT_IDX, BUSY, TIMEOUT, x.gnt, x.idx, x.busy, x.to);
      else n_pass++;
    end
  endtask

  // All four request; each holder keeps REQ for 3 grant cycles then drops it for one.
  task automatic test_round_robin();
    vec_t v[$];
    exp_t x;
    int ph, p;
    logic [3:0] r, g;
    v.push_back(mk(0, 1, 4'b1111, 4'b0000, 0, 0, 0));
    for (int t = 1; t <= 20; t++) begin
      ph = (t - 1) % 4;
      p  = ((t - 1) / 4) % 4;
      r  = 4'b1111;
      if (t % 4 == 0) r[(t / 4 - 1) % 4] = 1'b0;
      g = 4'b0000;
      if (ph < 3) g[p] = 1'b1;
      v.push_back(mk(1, 1, r, g, (ph < 3) ? 2'(p) : 2'd0, ph < 3, 0));
    end
    foreach (v[i]) begin
      RST = v[i].rst; EN = v[i].en; REQ = v[i].req;
      exp_q.push_back(to_exp(v[i]));
      @(posedge CK); #1;
      x = exp_q.pop_front();
      n_total++;
      if (GNT !== x.gnt || GNT_IDX !== x.idx || BUSY !== x.busy || TIMEOUT !== x.to)
        $display("FAIL round_robin[%0d] got gnt=%b idx=%0d busy=%b to=%b want gnt=%b idx=%0d busy=%b to=%b",
                 i, GNT, GNT_IDX, BUSY, TIMEOUT, x.gnt, x.idx, x.busy, x.to);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    vec_t v[$];
    exp_t x;
    v.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b0010, 4'b0010, 1, 1, 0));
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b0011, 4'b0001, 0, 1, 0));
    v.push_back(mk(1, 1, 4'b0010, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b0011, 4'b0010, 1, 1, 0));
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    foreach (v[i]) begin
      RST = v[i].rst; EN = v[i].en; REQ = v[i].req;
      exp_q.push_back(to_exp(v[i]));
      @(posedge CK); #1;
      x = exp_q.pop_front();
      n_total++;
      if (GNT !== x.gnt || GNT_IDX !== x.idx || BUSY !== x.busy || TIMEOUT !== x.to)
        $display("FAIL wrap[%0d] got gnt=%b idx=%0d busy=%b to=%b want gnt=%b idx=%0d busy=%b to=%b",
                 i, GNT, GNT_IDX, BUSY, TIMEOUT, x.gnt, x.idx, x.busy, x.to);
      else n_pass++;
    end
  endtask

  // EN gating in IDLE, EN ignored mid-grant, reset mid-grant returns token to bit 0.
  task automatic test_enable_and_midreset();
    vec_t v[$];
    exp_t x;
    v.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 0, 4'b0100, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 0, 4'b0100, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 0, 4'b0100, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b0100, 4'b0100, 2, 1, 0));
    v.push_back(mk(1, 0, 4'b0100, 4'b0100, 2, 1, 0));
    v.push_back(mk(1, 0, 4'b0101, 4'b0100, 2, 1, 0));
    v.push_back(mk(1, 0, 4'b0100, 4'b0100, 2, 1, 0));
    v.push_back(mk(1, 0, 4'b0000, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b0100, 4'b0100, 2, 1, 0));
    v.push_back(mk(0, 1, 4'b0100, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b1001, 4'b0001, 0, 1, 0));
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    foreach (v[i]) begin
      RST = v[i].rst; EN = v[i].en; REQ = v[i].req;
      exp_q.push_back(to_exp(v[i]));
      @(posedge CK); #1;
      x = exp_q.pop_front();
      n_total++;
      if (GNT !== x.gnt || GNT_IDX !== x.idx || BUSY !== x.busy || TIMEOUT !== x.to)
        $display("FAIL enable_midreset[%0d] got gnt=%b idx=%0d busy=%b to=%b want gnt=%b idx=%0d busy=%b to=%b",
                 i, GNT, GNT_IDX, BUSY, TIMEOUT, x.gnt, x.idx, x.busy, x.to);
      else n_pass++;
    end
  endtask

  // REQ[1] drops during the 8th grant cycle: ordinary release, no timeout pulse.
  task automatic test_release_at_limit();
    vec_t v[$];
    exp_t x;
    v.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0));
    for (int t = 1; t <= 8; t++) v.push_back(mk(1, 1, 4'b0010, 4'b0010, 1, 1, 0));
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    foreach (v[i]) begin
      RST = v[i].rst; EN = v[i].en; REQ = v[i].req;
      exp_q.push_back(to_exp(v[i]));
      @(posedge CK); #1;
      x = exp_q.pop_front();
      n_total++;
      if (GNT !== x.gnt || GNT_IDX !== x.idx || BUSY !== x.busy || TIMEOUT !== x.to)
        $display("FAIL release_at_limit[%0d] got gnt=%b idx=%0d busy=%b to=%b want gnt=%b idx=%0d busy=%b to=%b",
                 i, GNT, GNT_IDX, BUSY, TIMEOUT, x.gnt, x.idx, x.busy, x.to);
      else n_pass++;
    end
  endtask

`ifdef RING_ARB_TIMEOUT_EN
  // REQ[1] held: 8 grant cycles, one timeout/idle cycle, regrant, repeat.
  task automatic test_timeout();
    vec_t v[$];
    exp_t x;
    int k;
    v.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0));
    for (int t = 1; t <= 20; t++) begin
      k = (t - 1) % 9;
      v.push_back(mk(1, 1, 4'b0010, (k < 8) ? 4'b0010 : 4'b0000,
                     (k < 8) ? 2'd1 : 2'd0, k < 8, k == 8));
    end
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    foreach (v[i]) begin
      RST = v[i].rst; EN = v[i].en; REQ = v[i].req;
      exp_q.push_back(to_exp(v[i]));
      @(posedge CK); #1;
      x = exp_q.pop_front();
      n_total++;
      if (GNT !== x.gnt || GNT_IDX !== x.idx || BUSY !== x.busy || TIMEOUT !== x.to)
        $display("FAIL timeout[%0d] got gnt=%b idx=%0d busy=%b to=%b want gnt=%b idx=%0d busy=%b to=%b",
                 i, GNT, GNT_IDX, BUSY, TIMEOUT, x.gnt, x.idx, x.busy, x.to);
      else n_pass++;
    end
  endtask
`else
  task automatic test_long_hold();
    vec_t v[$];
    exp_t x;
    v.push_back(mk(0, 1, 4'b0000, 4'b0000, 0, 0, 0));
    for (int t = 1; t <= 300; t++) v.push_back(mk(1, 1, 4'b0001, 4'b0001, 0, 1, 0));
    v.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    foreach (v[i]) begin
      RST = v[i].rst; EN = v[i].en; REQ = v[i].req;
      exp_q.push_back(to_exp(v[i]));
      @(posedge CK); #1;
      x = exp_q.pop_front();
      n_total++;
      if (GNT !== x.gnt || GNT_IDX !== x.idx || BUSY !== x.busy || TIMEOUT !== x.to)
        $display("FAIL long_hold[%0d] got gnt=%b idx=%0d busy=%b to=%b want gnt=%b idx=%0d busy=%b to=%b",
                 i, GNT, GNT_IDX, BUSY, TIMEOUT, x.gnt, x.idx, x.busy, x.to);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    EN  = 1'b0;
    REQ = 4'b0000;
    test_reset();
    test_round_robin();
    test_wrap();
    test_enable_and_midreset();
    test_release_at_limit();
`ifdef RING_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
